// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM:
// opcode/funct constants, ALU operation codes and state encoding.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_WB_R    = 4'd3,
    S_EXEC_I  = 4'd4,
    S_WB_I    = 4'd5,
    S_MEM_ADR = 4'd6,
    S_MEM_RD  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'd0,
    ALU_CLS_SUB   = 2'd1,
    ALU_CLS_FUNCT = 2'd2,
    ALU_CLS_SLT   = 2'd3
  } alu_cls_t;

  // R-type funct codes that execute through EXEC_R/WB_R (jr is handled separately)
  function automatic logic funct_is_alu(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU operation select from the FSM's state class and the
// instruction funct field.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_cls_t   alu_cls,
  input  logic [5:0] funct,
  output logic [2:0] alu_opc
);

  always_comb begin
    alu_opc = ALU_ADD;
    case (alu_cls)
      ALU_CLS_ADD: alu_opc = ALU_ADD;
      ALU_CLS_SUB: alu_opc = ALU_SUB;
      ALU_CLS_SLT: alu_opc = ALU_SLT;
      ALU_CLS_FUNCT: begin
        case (funct)
          FN_ADD:  alu_opc = ALU_ADD;
          FN_SUB:  alu_opc = ALU_SUB;
          FN_AND:  alu_opc = ALU_AND;
          FN_OR:   alu_opc = ALU_OR;
          FN_SLT:  alu_opc = ALU_SLT;
          default: alu_opc = ALU_ADD;
        endcase
      end
      default: alu_opc = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the word-addressed MIPS-subset datapath.
// state     | meaning
// FETCH     | read instr at PC, PC+1; wait mem_ready
// DECODE    | dispatch on opcode/funct; illegal exits here
// EXEC_R    | R-type ALU op       WB_R   | write rd
// EXEC_I    | imm ALU op          WB_I   | write rt
// MEM_ADR   | base + imm          MEM_RD | load wait   WB_MEM | write rt
// MEM_WR    | store wait          BRANCH | beq compare
// JUMP/JAL  | PC = imm26 (+ r31 link)    JR | PC = RegA
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             init,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_dst,
  output logic             r31,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             write_pc_4,
  output logic             branch,
  output logic             adr_r31,
  output logic             jump,
  output logic [2:0]       ALU_opc,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t   state, next_state;
  alu_cls_t alu_cls;
  logic     retire;

  always_ff @(posedge clk or posedge init) begin
    if (init) state <= S_FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    r31        = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    write_pc_4 = 1'b0;
    branch     = 1'b0;
    adr_r31    = 1'b0;
    jump       = 1'b0;
    illegal    = 1'b0;
    alu_cls    = ALU_CLS_ADD;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R: begin
            if (funct == FN_JR)          next_state = S_JR;
            else if (funct_is_alu(funct)) next_state = S_EXEC_R;
            else begin
              illegal    = 1'b1;
              next_state = S_FETCH;
            end
          end
          OP_ADDI, OP_SLTI: next_state = S_EXEC_I;
          OP_LW, OP_SW:     next_state = S_MEM_ADR;
          OP_BEQ:           next_state = S_BRANCH;
          OP_J:             next_state = S_JUMP;
          OP_JAL:           next_state = S_JAL;
          default: begin
            illegal    = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_cls    = ALU_CLS_FUNCT;
        next_state = S_WB_R;
      end
      S_WB_R: begin
        alu_cls    = ALU_CLS_FUNCT;
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src    = 1'b1;
        alu_cls    = (opcode == OP_SLTI) ? ALU_CLS_SLT : ALU_CLS_ADD;
        next_state = S_WB_I;
      end
      S_WB_I: begin
        alu_src    = 1'b1;
        alu_cls    = (opcode == OP_SLTI) ? ALU_CLS_SLT : ALU_CLS_ADD;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADR: begin
        alu_src    = 1'b1;
        next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) next_state = S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_cls    = ALU_CLS_SUB;
        branch     = 1'b1;
        pc_write   = zero;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        jump       = 1'b1;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        jump       = 1'b1;
        pc_write   = 1'b1;
        r31        = 1'b1;
        write_pc_4 = 1'b1;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_JR: begin
        adr_r31    = 1'b1;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  multicycle_controller_alu_decoder u_alu_decoder (
    .alu_cls (alu_cls),
    .funct   (funct),
    .alu_opc (ALU_opc)
  );

  // An instruction retires on its last cycle; fetch stalls and illegal exits do not count.
  assign retire = (next_state == S_FETCH) && (state != S_FETCH) && !illegal;

  always_ff @(posedge clk or posedge init) begin
    if (init)        retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded bench: each scenario pushes per-cycle expected controls, then
// drives the cycles and compares against the popped expectations.
module tb_multicycle_controller;

  localparam int CW = 4;

  localparam int F = 0, D = 1, XR = 2, WR = 3, XI = 4, WI = 5, MA = 6, MR = 7;
  localparam int WM = 8, MW = 9, BR = 10, JP = 11, JL = 12, JRS = 13;

  logic          clk = 1'b0;
  logic          init = 1'b1;
  logic [5:0]    opcode = 6'b0;
  logic [5:0]    funct = 6'b0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_write, ir_write, iord, mem_read, mem_write, reg_dst, r31;
  logic          reg_write, alu_src, mem_to_reg, write_pc_4, branch, adr_r31;
  logic          jump, illegal;
  logic [2:0]    ALU_opc;
  logic [CW-1:0] retired;
  logic [17:0]   ctl_now;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [5:0]    op;
    logic [5:0]    fn;
    logic          rdy;
    logic          z;
    logic [17:0]   ctl;
    logic [17:0]   mask;
    logic [CW-1:0] ret;
    string         tag;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  logic [CW-1:0] exp_ret = '0;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .init(init), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_dst(reg_dst), .r31(r31), .reg_write(reg_write), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .write_pc_4(write_pc_4), .branch(branch),
    .adr_r31(adr_r31), .jump(jump), .ALU_opc(ALU_opc), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  assign ctl_now = {pc_write, ir_write, iord, mem_read, mem_write, reg_dst, r31,
                    reg_write, alu_src, mem_to_reg, write_pc_4, branch, adr_r31,
                    jump, ALU_opc, illegal};

  function automatic logic known(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000)
      return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};
    return op inside {6'b001000, 6'b001010, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
  endfunction

  function automatic logic [2:0] falu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [17:0] exp_ctl(input int st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z, input logic rdy);
    logic pcw = 0, irw = 0, io = 0, mr = 0, mw = 0, rd = 0, l31 = 0, rw = 0;
    logic as = 0, m2r = 0, wp4 = 0, br = 0, ar = 0, jm = 0, ill = 0;
    logic [2:0] alu = 3'b010;
    case (st)
      F:   begin mr = 1; pcw = rdy; irw = rdy; end
      D:   ill = !known(op, fn);
      XR:  alu = falu(fn);
      WR:  begin rd = 1; rw = 1; alu = falu(fn); end
      XI:  begin as = 1; alu = (op == 6'b001010) ? 3'b111 : 3'b010; end
      WI:  begin as = 1; rw = 1; alu = (op == 6'b001010) ? 3'b111 : 3'b010; end
      MA:  as = 1;
      MR:  begin io = 1; mr = 1; end
      WM:  begin m2r = 1; rw = 1; end
      MW:  begin io = 1; mw = 1; end
      BR:  begin alu = 3'b110; br = 1; pcw = z; end
      JP:  begin jm = 1; pcw = 1; end
      JL:  begin jm = 1; pcw = 1; l31 = 1; wp4 = 1; rw = 1; end
      JRS: begin ar = 1; pcw = 1; end
      default: ;
    endcase
    return {pcw, irw, io, mr, mw, rd, l31, rw, as, m2r, wp4, br, ar, jm, alu, ill};
  endfunction

  task automatic push_state(input int st, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input logic rdy, input string tag);
    exp_t x;
    x.op = op; x.fn = fn; x.rdy = rdy; x.z = z; x.tag = tag;
    x.ctl = exp_ctl(st, op, fn, z, rdy);
    x.mask = (st inside {F, XR, WR, XI, WI, MA, BR}) ? 18'h3FFFF : 18'h3FFF1;
    x.ret = exp_ret;
    exp_q.push_back(x);
  endtask

  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fwait, input int mwait, input logic idle, input string tag);
    repeat (fwait) push_state(F, op, fn, z, 1'b0, tag);
    push_state(F, op, fn, z, 1'b1, tag);
    push_state(D, op, fn, z, idle, tag);
    if (!known(op, fn)) return;
    case (op)
      6'b000000: if (fn == 6'b001000) push_state(JRS, op, fn, z, idle, tag);
                 else begin push_state(XR, op, fn, z, idle, tag); push_state(WR, op, fn, z, idle, tag); end
      6'b001000, 6'b001010: begin push_state(XI, op, fn, z, idle, tag); push_state(WI, op, fn, z, idle, tag); end
      6'b100011: begin
        push_state(MA, op, fn, z, idle, tag);
        repeat (mwait) push_state(MR, op, fn, z, 1'b0, tag);
        push_state(MR, op, fn, z, 1'b1, tag);
        push_state(WM, op, fn, z, idle, tag);
      end
      6'b101011: begin
        push_state(MA, op, fn, z, idle, tag);
        repeat (mwait) push_state(MW, op, fn, z, 1'b0, tag);
        push_state(MW, op, fn, z, 1'b1, tag);
      end
      6'b000100: push_state(BR, op, fn, z, idle, tag);
      6'b000010: push_state(JP, op, fn, z, idle, tag);
      6'b000011: push_state(JL, op, fn, z, idle, tag);
      default: ;
    endcase
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic test_reset();
    init = 1'b1; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (ctl_now !== 18'b000100000000000100) begin
      bad++; $display("FAIL reset_ctl: got %b want %b", ctl_now, 18'b000100000000000100);
    end
    total++;
    if (retired !== '0) begin bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
    init = 1'b0;
  endtask

  task automatic test_r_type();
    push_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b1, "add");
    push_instr(6'b000000, 6'b100010, 1'b0, 1, 0, 1'b0, "sub");
    push_instr(6'b000000, 6'b100100, 1'b0, 0, 0, 1'b1, "and");
    push_instr(6'b000000, 6'b100101, 1'b0, 0, 0, 1'b0, "or");
    push_instr(6'b000000, 6'b101010, 1'b0, 2, 0, 1'b1, "slt");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); opcode = e.op; funct = e.fn; mem_ready = e.rdy; zero = e.z; #1;
      total++;
      if ((ctl_now & e.mask) !== (e.ctl & e.mask)) begin
        bad++; $display("FAIL rtype_%s_ctl: got %b want %b", e.tag, ctl_now, e.ctl);
      end
      total++;
      if (retired !== e.ret) begin bad++; $display("FAIL rtype_%s_retired: got %0d want %0d", e.tag, retired, e.ret); end
    end
  endtask

  task automatic test_lw_wait();
    push_instr(6'b100011, 6'b000000, 1'b0, 0, 2, 1'b1, "lw");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); opcode = e.op; funct = e.fn; mem_ready = e.rdy; zero = e.z; #1;
      total++;
      if ((ctl_now & e.mask) !== (e.ctl & e.mask)) begin
        bad++; $display("FAIL lw_ctl: got %b want %b", ctl_now, e.ctl);
      end
      total++;
      if (retired !== e.ret) begin bad++; $display("FAIL lw_retired: got %0d want %0d", retired, e.ret); end
    end
  endtask

  task automatic test_beq();
    push_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b1, "beq_taken");
    push_instr(6'b000100, 6'b000000, 1'b0, 0, 0, 1'b1, "beq_not");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); opcode = e.op; funct = e.fn; mem_ready = e.rdy; zero = e.z; #1;
      total++;
      if ((ctl_now & e.mask) !== (e.ctl & e.mask)) begin
        bad++; $display("FAIL %s_ctl: got %b want %b", e.tag, ctl_now, e.ctl);
      end
      total++;
      if (retired !== e.ret) begin bad++; $display("FAIL %s_retired: got %0d want %0d", e.tag, retired, e.ret); end
    end
  endtask

  task automatic test_jal_jr();
    push_instr(6'b000011, 6'b000000, 1'b0, 0, 0, 1'b1, "jal");
    push_instr(6'b000000, 6'b001000, 1'b0, 0, 0, 1'b0, "jr");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); opcode = e.op; funct = e.fn; mem_ready = e.rdy; zero = e.z; #1;
      total++;
      if ((ctl_now & e.mask) !== (e.ctl & e.mask)) begin
        bad++; $display("FAIL %s_ctl: got %b want %b", e.tag, ctl_now, e.ctl);
      end
      total++;
      if (retired !== e.ret) begin bad++; $display("FAIL %s_retired: got %0d want %0d", e.tag, retired, e.ret); end
    end
  endtask

  task automatic test_illegal();
    push_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b1, "ill_op");
    push_instr(6'b000000, 6'b000000, 1'b0, 0, 0, 1'b1, "ill_fn");
    push_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b1, "j_after_ill");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); opcode = e.op; funct = e.fn; mem_ready = e.rdy; zero = e.z; #1;
      total++;
      if ((ctl_now & e.mask) !== (e.ctl & e.mask)) begin
        bad++; $display("FAIL %s_ctl: got %b want %b", e.tag, ctl_now, e.ctl);
      end
      total++;
      if (retired !== e.ret) begin bad++; $display("FAIL %s_retired: got %0d want %0d", e.tag, retired, e.ret); end
    end
  endtask

  task automatic test_init_abort();
    logic [CW-1:0] saved;
    saved = exp_ret;
    push_instr(6'b101011, 6'b000000, 1'b0, 0, 1, 1'b1, "sw_abort");
    void'(exp_q.pop_back());
    exp_ret = saved;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); opcode = e.op; funct = e.fn; mem_ready = e.rdy; zero = e.z; #1;
      total++;
      if ((ctl_now & e.mask) !== (e.ctl & e.mask)) begin
        bad++; $display("FAIL %s_ctl: got %b want %b", e.tag, ctl_now, e.ctl);
      end
      total++;
      if (retired !== e.ret) begin bad++; $display("FAIL %s_retired: got %0d want %0d", e.tag, retired, e.ret); end
    end
    #1 init = 1'b1;
    #1;
    total++;
    if ({mem_write, mem_read, iord, reg_write, pc_write} !== 5'b01000) begin
      bad++; $display("FAIL abort_ctl: got %b want 01000", {mem_write, mem_read, iord, reg_write, pc_write});
    end
    total++;
    if (retired !== '0) begin bad++; $display("FAIL abort_retired: got %0d want 0", retired); end
    @(posedge clk); #1;
    total++;
    if ({mem_write, reg_write, pc_write} !== 3'b000) begin
      bad++; $display("FAIL abort_hold: got %b want 000", {mem_write, reg_write, pc_write});
    end
    @(negedge clk); init = 1'b0;
    exp_ret = '0;
    push_instr(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1, "sw_after");
    push_state(F, 6'b0, 6'b0, 1'b0, 1'b0, "sw_after_fetch");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); opcode = e.op; funct = e.fn; mem_ready = e.rdy; zero = e.z; #1;
      total++;
      if ((ctl_now & e.mask) !== (e.ctl & e.mask)) begin
        bad++; $display("FAIL %s_ctl: got %b want %b", e.tag, ctl_now, e.ctl);
      end
      total++;
      if (retired !== e.ret) begin bad++; $display("FAIL %s_retired: got %0d want %0d", e.tag, retired, e.ret); end
    end
  endtask

  task automatic test_back_to_back();
    push_instr(6'b001000, 6'b000000, 1'b0, 0, 0, 1'b0, "addi");
    push_instr(6'b001010, 6'b000000, 1'b0, 1, 0, 1'b1, "slti");
    push_instr(6'b100011, 6'b000000, 1'b0, 0, 0, 1'b0, "lw0");
    push_instr(6'b101011, 6'b000000, 1'b0, 0, 0, 1'b1, "sw0");
    for (int i = 0; i < 16; i++)
      push_instr(6'b000010, 6'b000000, 1'(i % 2), 0, 0, 1'(i % 3 == 0), "j_wrap");
    push_state(F, 6'b0, 6'b0, 1'b0, 1'b0, "final_fetch");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk); opcode = e.op; funct = e.fn; mem_ready = e.rdy; zero = e.z; #1;
      total++;
      if ((ctl_now & e.mask) !== (e.ctl & e.mask)) begin
        bad++; $display("FAIL b2b_%s_ctl: got %b want %b", e.tag, ctl_now, e.ctl);
      end
      total++;
      if (retired !== e.ret) begin bad++; $display("FAIL b2b_%s_retired: got %0d want %0d", e.tag, retired, e.ret); end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_beq();
    test_jal_jr();
    test_illegal();
    test_init_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences the multi-cycle build of the 32-bit word-addressed MIPS-subset datapath. It fetches over a shared instruction/data memory with a ready handshake, decodes opcode/funct, and drives per-state datapath controls.
- Supported instructions: add, sub, and, or, slt, jr, addi, slti, lw, sw, beq, j, jal.
- Also provides an illegal-instruction pulse and a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
init  input  1  reset, asynchronous, active-high
opcode  input  6  Inst[31:26] from instruction register
funct  input  6  Inst[5:0] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current read/write this cycle
pc_write  output  1  PC load enable
ir_write  output  1  instruction register load enable
iord  output  1  memory address select: 0 = PC, 1 = ALU result register
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_dst  output  1  write register = Inst[15:11]
r31  output  1  write register = 31
reg_write  output  1  register file write enable
alu_src  output  1  ALU B = sign-extended imm16
mem_to_reg  output  1  write data = memory data register
write_pc_4  output  1  write data = PC (already incremented)
branch  output  1  PC load if zero
adr_r31  output  1  next PC = RegA
jump  output  1  next PC = sign-extended imm26
ALU_opc  output  3  ALU operation
illegal  output  1  one-cycle pulse on unknown opcode/funct
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset (async, init=1): state FETCH; retired=0; illegal=0. In FETCH, mem_read=1, iord=0, and every other control is 0.
- Outputs are Moore (state only), except pc_write and ir_write, which are also qualified by mem_ready/zero as below.
- ALU_opc encoding: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- Opcodes: R 000000, addi 001000, slti 001010, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
- States and transitions:
  - FETCH: mem_read=1, iord=0, ALU_opc=add (PC+1). Holds until mem_ready=1; in that cycle ir_write=1 and pc_write=1, then go to DECODE.
  - DECODE: no side effects. Next state by opcode: R (non-jr) to EXEC_R; jr to JR; addi/slti to EXEC_I; lw/sw to MEM_ADR; beq to BRANCH; j to JUMP; jal to JAL. Anything else: illegal=1 for this cycle, go to FETCH, retired unchanged.
  - EXEC_R: ALU_opc from funct, alu_src=0, go to WB_R.
  - WB_R: reg_dst=1, reg_write=1, ALU_opc held, go to FETCH.
  - EXEC_I: alu_src=1; ALU_opc add (addi) or slt (slti); go to WB_I.
  - WB_I: reg_dst=0, reg_write=1, controls held, go to FETCH.
  - MEM_ADR: alu_src=1, ALU_opc=add. Go to MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: iord=1, mem_read=1; hold until mem_ready, then go to WB_MEM.
  - WB_MEM: mem_to_reg=1, reg_write=1, reg_dst=0, go to FETCH.
  - MEM_WR: iord=1, mem_write=1; hold until mem_ready, then go to FETCH.
  - BRANCH: ALU_opc=sub, branch=1, pc_write=zero, go to FETCH.
  - JUMP: jump=1, pc_write=1, go to FETCH.
  - JAL: jump=1, pc_write=1, r31=1, write_pc_4=1, reg_write=1, go to FETCH.
  - JR: adr_r31=1, pc_write=1, go to FETCH.
- Latency with mem_ready tied high: beq/j/jal/jr 3 cycles; R/addi/slti/sw 4; lw 5. Each memory wait cycle adds 1.
- retired increments by 1 in each cycle whose next state is FETCH, except the DECODE-illegal exit and FETCH self-loop. It wraps at 2^CNT_W−1 to 0.
- mem_read and mem_write are never high together. mem_read/mem_write stay stable while waiting for mem_ready.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- init asserted mid-instruction aborts at once: no reg_write/mem_write/pc_write after the init edge; state returns to FETCH.

Decomposition:
- Shared package: opcode and funct constants, ALU_opc encodings, FSM state encoding (4-bit localparams).
- One sub-module, alu_decoder: maps (state class: fetch/add, sub, funct, imm-slt) plus funct to ALU_opc. Purely combinational.

Test Plan:
1. add (opcode 000000, funct 100000), mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_R; reg_write=1 with reg_dst=1, ALU_opc=010 in cycle 4; retired 0→1.
2. lw (100011), mem_ready low 2 cycles in MEM_RD -> mem_read=1, iord=1 held 3 cycles; WB_MEM asserts mem_to_reg=1, reg_write=1; total 7 cycles.
3. beq with zero=1, then with zero=0 -> pc_write=1 and 0 respectively in BRANCH; ALU_opc=110; 3 cycles each.
4. jal (000011) -> JAL cycle asserts jump, r31, write_pc_4, reg_write, pc_write all =1; jr (funct 001000) -> adr_r31=1, pc_write=1, reg_write=0.
5. opcode 111111 -> illegal pulses exactly 1 cycle in DECODE, no reg_write/mem_write, retired unchanged, FETCH next.
6. init asserted during MEM_WR with mem_ready=0 -> mem_write drops immediately, state FETCH, retired=0; a following sw completes normally.
